// File: rtl/cr_huf_compPKG.sv
// Shared types for the Huffman compressor: pipe end-of-block codes and scheduler FSM states.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 64
`endif

package cr_huf_compPKG;

  localparam int unsigned SEQID_W = `CREOLE_HC_SEQID_WIDTH;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    PASS_THRU = 2'd1,
    EOB       = 2'd2
  } e_pipe_eob;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } e_is_sched_state;

endpackage

// File: rtl/cr_huf_comp_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, returned one-hot and as an index.
module cr_huf_comp_rr_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_is_sched.sv
// Insertion-sorter job scheduler: round-robin launch, ownership tracking, completion pulses.
// Optional WAIT watchdog compiled in with CR_HUF_IS_SCHED_WDOG_EN.
module cr_huf_comp_is_sched
  import cr_huf_compPKG::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DAT_WIDTH   = 10,
  parameter int unsigned CNTRL_WIDTH = 1,
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  e_pipe_eob [NUM_REQ-1:0]               req_eob,
  input  logic [NUM_REQ-1:0][CNTRL_WIDTH-1:0]   req_meta,
  input  logic [NUM_REQ-1:0][SEQID_W-1:0]       req_seq_id,
  input  logic [NUM_REQ-1:0][DAT_WIDTH-1:0]     req_sym_lo,
  input  logic [NUM_REQ-1:0][DAT_WIDTH-1:0]     req_sym_hi,
  output logic [NUM_REQ-1:0]                    req_grant,
  output logic [NUM_REQ-1:0]                    req_done,
  output e_pipe_eob                             sched_eob,
  output logic [CNTRL_WIDTH-1:0]                sched_meta,
  output logic [SEQID_W-1:0]                    sched_seq_id,
  output logic [DAT_WIDTH-1:0]                  sched_sym_lo,
  output logic [DAT_WIDTH-1:0]                  sched_sym_hi,
  input  logic                                  sorter_not_ready,
  input  e_pipe_eob                             sorter_eob,
  output logic [$clog2(NUM_REQ)-1:0]            owner,
  output logic                                  busy,
  output logic                                  wdog_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || WDOG_CYCLES < 1) begin : g_param_chk
    $error("cr_huf_comp_is_sched: NUM_REQ must be >= 2 and WDOG_CYCLES >= 1");
  end

  e_is_sched_state        state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]     req_grant_q, req_grant_d;
  e_pipe_eob              sched_eob_q, sched_eob_d;
  logic [CNTRL_WIDTH-1:0] sched_meta_q, sched_meta_d;
  logic [SEQID_W-1:0]     sched_seq_id_q, sched_seq_id_d;
  logic [DAT_WIDTH-1:0]   sched_sym_lo_q, sched_sym_lo_d;
  logic [DAT_WIDTH-1:0]   sched_sym_hi_q, sched_sym_hi_d;
  logic                   busy_q, busy_d;
  logic                   wdog_hit;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   sorter_end;

  assign sorter_end = (sorter_eob != MIDDLE);

  cr_huf_comp_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any && !sorter_not_ready) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (sorter_end || wdog_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; req_done is a same-cycle decode of the sorter result
  always_comb begin
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    req_grant_d    = '0;
    sched_eob_d    = MIDDLE;
    sched_meta_d   = sched_meta_q;
    sched_seq_id_d = sched_seq_id_q;
    sched_sym_lo_d = sched_sym_lo_q;
    sched_sym_hi_d = sched_sym_hi_q;
    busy_d         = (state_d != IDLE);
    req_done       = '0;
    if (state_q == IDLE && state_d == LAUNCH) begin
      owner_d        = arb_idx;
      req_grant_d    = arb_gnt;
      sched_eob_d    = req_eob[arb_idx];
      sched_meta_d   = req_meta[arb_idx];
      sched_seq_id_d = req_seq_id[arb_idx];
      sched_sym_lo_d = req_sym_lo[arb_idx];
      sched_sym_hi_d = req_sym_hi[arb_idx];
    end
    if (state_q == LAUNCH) begin
      ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end
    if (state_q == WAIT && sorter_end) begin
      req_done[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      owner_q        <= '0;
      req_grant_q    <= '0;
      sched_eob_q    <= MIDDLE;
      sched_meta_q   <= '0;
      sched_seq_id_q <= '0;
      sched_sym_lo_q <= '0;
      sched_sym_hi_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      req_grant_q    <= req_grant_d;
      sched_eob_q    <= sched_eob_d;
      sched_meta_q   <= sched_meta_d;
      sched_seq_id_q <= sched_seq_id_d;
      sched_sym_lo_q <= sched_sym_lo_d;
      sched_sym_hi_q <= sched_sym_hi_d;
      busy_q         <= busy_d;
    end
  end

`ifdef CR_HUF_IS_SCHED_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q, wdog_err_d;

  // Counter sits at zero outside WAIT, so it is clear on every WAIT entry
  always_comb begin
    wdog_hit   = (state_q == WAIT) && (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1)) && !sorter_end;
    wdog_cnt_d = (state_q == WAIT) ? wdog_cnt_q + CNT_W'(1) : '0;
    wdog_err_d = wdog_err_q | wdog_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign req_grant    = req_grant_q;
  assign sched_eob    = sched_eob_q;
  assign sched_meta   = sched_meta_q;
  assign sched_seq_id = sched_seq_id_q;
  assign sched_sym_lo = sched_sym_lo_q;
  assign sched_sym_hi = sched_sym_hi_q;
  assign owner        = owner_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cr_huf_comp_is_sched.sv
// Directed bench for cr_huf_comp_is_sched (NUM_REQ=2, WDOG_CYCLES=16).
module tb_cr_huf_comp_is_sched;
  import cr_huf_compPKG::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             req_valid;
  e_pipe_eob [1:0]        req_eob;
  logic [1:0][0:0]        req_meta;
  logic [1:0][SEQID_W-1:0] req_seq_id;
  logic [1:0][9:0]        req_sym_lo;
  logic [1:0][9:0]        req_sym_hi;
  logic [1:0]             req_grant;
  logic [1:0]             req_done;
  e_pipe_eob              sched_eob;
  logic [0:0]             sched_meta;
  logic [SEQID_W-1:0]     sched_seq_id;
  logic [9:0]             sched_sym_lo;
  logic [9:0]             sched_sym_hi;
  logic                   sorter_not_ready;
  e_pipe_eob              sorter_eob;
  logic [0:0]             owner;
  logic                   busy;
  logic                   wdog_err;

  int checks = 0;
  int errors = 0;

  cr_huf_comp_is_sched #(
    .NUM_REQ(2), .DAT_WIDTH(10), .CNTRL_WIDTH(1), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_eob(req_eob), .req_meta(req_meta),
    .req_seq_id(req_seq_id), .req_sym_lo(req_sym_lo), .req_sym_hi(req_sym_hi),
    .req_grant(req_grant), .req_done(req_done), .sched_eob(sched_eob), .sched_meta(sched_meta),
    .sched_seq_id(sched_seq_id), .sched_sym_lo(sched_sym_lo), .sched_sym_hi(sched_sym_hi),
    .sorter_not_ready(sorter_not_ready), .sorter_eob(sorter_eob), .owner(owner),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(req_grant), 64'd0);
    chk({tag, "_done"},  64'(req_done), 64'd0);
    chk({tag, "_eob"},   64'(sched_eob), 64'(MIDDLE));
    chk({tag, "_meta"},  64'(sched_meta), 64'd0);
    chk({tag, "_seq"},   64'(sched_seq_id), 64'd0);
    chk({tag, "_lo"},    64'(sched_sym_lo), 64'd0);
    chk({tag, "_hi"},    64'(sched_sym_hi), 64'd0);
    chk({tag, "_owner"}, 64'(owner), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_wdog"},  64'(wdog_err), 64'd0);
  endtask

  // Ticks until a grant shows; clears sorter_eob after the first edge
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      sorter_eob = MIDDLE;
      n++;
    end while (req_grant == 2'b00 && n < 12);
  endtask

  initial begin
    int n;
    logic [1:0] exp_oh;
    rst = 1'b1;
    req_valid = '0;
    req_eob = {MIDDLE, MIDDLE};
    req_meta = '0;
    req_seq_id = '0;
    req_sym_lo = '0;
    req_sym_hi = '0;
    sorter_not_ready = 1'b0;
    sorter_eob = MIDDLE;
    tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Single PASS_THRU job from requester 0; sorter answers at t+5
    req_valid[0] = 1'b1; req_eob[0] = PASS_THRU; req_meta[0] = 1'b1;
    req_seq_id[0] = 64'h5; req_sym_lo[0] = 10'd0; req_sym_hi[0] = 10'd575;
    tick();
    chk("t1_grant", 64'(req_grant), 64'b01);
    chk("t1_eob",   64'(sched_eob), 64'(PASS_THRU));
    chk("t1_hi",    64'(sched_sym_hi), 64'd575);
    chk("t1_meta",  64'(sched_meta), 64'd1);
    chk("t1_seq",   64'(sched_seq_id), 64'h5);
    chk("t1_busy",  64'(busy), 64'd1);
    req_valid = '0;
    tick();
    chk("t1_grant2", 64'(req_grant), 64'b00);
    chk("t1_eob2",   64'(sched_eob), 64'(MIDDLE));
    chk("t1_hold",   64'(sched_sym_hi), 64'd575);
    tick(); chk("t1_nodone3", 64'(req_done), 64'b00);
    tick(); chk("t1_nodone4", 64'(req_done), 64'b00);
    tick();
    sorter_eob = EOB;
    #1;
    chk("t1_done", 64'(req_done), 64'b01);
    tick();
    sorter_eob = MIDDLE;
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_done_off", 64'(req_done), 64'b00);

    // Both requesters continuously valid after a fresh reset: grants 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req_eob = {PASS_THRU, EOB};
    req_sym_lo = {10'd7, 10'd3};
    req_sym_hi = {10'd11, 10'd9};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(n);
      chk($sformatf("rr%0d_gap", k), 64'(n), (k == 0) ? 64'd1 : 64'd2);
      chk($sformatf("rr%0d_grant", k), 64'(req_grant), 64'(exp_oh));
      chk($sformatf("rr%0d_owner", k), 64'(owner), 64'(k % 2));
      chk($sformatf("rr%0d_lo", k), 64'(sched_sym_lo), (k % 2 == 0) ? 64'd3 : 64'd7);
      chk($sformatf("rr%0d_eob", k), 64'(sched_eob), (k % 2 == 0) ? 64'(EOB) : 64'(PASS_THRU));
      tick(); tick();
      sorter_eob = EOB;
      #1;
      chk($sformatf("rr%0d_done", k), 64'(req_done), 64'(exp_oh));
      chk($sformatf("rr%0d_downer", k), 64'(owner), 64'(k % 2));
    end
    tick();
    sorter_eob = MIDDLE;
    req_valid = 2'b00;
    tick();
    chk("rr_end_busy", 64'(busy), 64'd0);
    chk("rr_end_grant", 64'(req_grant), 64'b00);

    // Sorter busy holds IDLE with requester 1 waiting
    sorter_not_ready = 1'b1;
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("nr%0d_grant", k), 64'(req_grant), 64'b00);
      chk($sformatf("nr%0d_busy", k), 64'(busy), 64'd0);
    end
    sorter_not_ready = 1'b0;
    tick();
    chk("nr_grant", 64'(req_grant), 64'b10);
    chk("nr_owner", 64'(owner), 64'd1);
    req_valid = 2'b00;
    tick(); tick();
    sorter_eob = EOB;
    #1;
    chk("nr_done", 64'(req_done), 64'b10);
    tick();
    sorter_eob = MIDDLE;

    // Reset in WAIT; a later sorter result must be ignored
    req_valid = 2'b10;
    tick();
    chk("rw_grant", 64'(req_grant), 64'b10);
    req_valid = 2'b00;
    tick(); tick();
    chk("rw_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rw");
    tick();
    rst = 1'b0;
    tick();
    sorter_eob = EOB;
    #1;
    chk("rw_late_done", 64'(req_done), 64'b00);
    tick();
    sorter_eob = MIDDLE;
    chk("rw_late_busy", 64'(busy), 64'd0);
    chk("rw_late_grant", 64'(req_grant), 64'b00);

`ifdef CR_HUF_IS_SCHED_WDOG_EN
    // Sorter never answers: 16 WAIT cycles then timeout
    req_valid = 2'b01;
    tick();
    chk("wd_grant", 64'(req_grant), 64'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 16; k++) tick();
    chk("wd_busy_last", 64'(busy), 64'd1);
    chk("wd_err_early", 64'(wdog_err), 64'd0);
    tick();
    chk("wd_busy_off", 64'(busy), 64'd0);
    chk("wd_err", 64'(wdog_err), 64'd1);
    tick();
    sorter_eob = EOB;
    #1;
    chk("wd_late_done", 64'(req_done), 64'b00);
    tick();
    sorter_eob = MIDDLE;
    chk("wd_sticky", 64'(wdog_err), 64'd1);
`else
    // Without the watchdog WAIT lasts as long as the sorter takes
    req_valid = 2'b01;
    tick();
    chk("nw_grant", 64'(req_grant), 64'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 20; k++) tick();
    chk("nw_busy", 64'(busy), 64'd1);
    chk("nw_err", 64'(wdog_err), 64'd0);
    sorter_eob = EOB;
    #1;
    chk("nw_done", 64'(req_done), 64'b01);
    tick();
    sorter_eob = MIDDLE;
    chk("nw_idle", 64'(busy), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
